// File: rtl/mio_ctrl_if.sv
// IOB -> MIO push interface.
// Carries the one-cycle push strobe, the port select and the push data from
// the I/O bus side. It returns the one-cycle UART frame-complete pulse.
//   iob__mio_val    push strobe, one cycle per request
//   iob__mio_port   0 = GPIO, 1 = UART
//   iob__mio_wdata  push data (UART uses [7:0], GPIO uses the low GPIO_W bits)
//   mio__iob_done   one-cycle pulse when a UART frame's stop bit completes
interface mio_ctrl_if;
    logic        iob__mio_val;
    logic        iob__mio_port;
    logic [31:0] iob__mio_wdata;
    logic        mio__iob_done;

    modport master (
        output iob__mio_val,
        output iob__mio_port,
        output iob__mio_wdata,
        input  mio__iob_done
    );

    modport slave (
        input  iob__mio_val,
        input  iob__mio_port,
        input  iob__mio_wdata,
        output mio__iob_done
    );
endinterface

// File: rtl/mio_ctrl.sv
// MIO responder: GPIO output bank plus 8N1 UART transmitter.
// GPIO pushes load the output register at the push edge and never produce
// done. UART pushes start one frame and return done when its stop bit ends.
//   clk             core clock
//   rst             asynchronous reset, active-high
//   iob             push interface (slave side)
//   mio__uart_tx    serial TX line, idle high
//   mio__uart_busy  high while the transmitter is not idle
//   mio__gpio_out   GPIO output register
//
// state   | meaning
// S_IDLE  | line idle high, waiting for a UART push
// S_START | start bit (low) being held for one bit time
// S_DATA  | data bits 0..7, LSB first, bit_cnt selects the bit
// S_STOP  | stop bit (high) being held for one bit time
module mio_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GPIO_W       = 32,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    mio_ctrl_if.slave         iob,
    output logic              mio__uart_tx,
    output logic              mio__uart_busy,
    output logic [GPIO_W-1:0] mio__gpio_out
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t             state_q, state_nx;
    logic [CNT_W-1:0]   baud_q, baud_nx;
    logic [2:0]         bit_q, bit_nx;
    logic [7:0]         shreg_q, shreg_nx;
    logic               tx_q, tx_nx;
    logic               busy_q, busy_nx;
    logic               done_q, done_nx;
    logic [GPIO_W-1:0]  gpio_q;

    logic uart_push;
    logic gpio_push;
    logic baud_tc;
    logic uart_take;

    assign uart_push = iob.iob__mio_val & iob.iob__mio_port;
    assign gpio_push = iob.iob__mio_val & ~iob.iob__mio_port;
    assign baud_tc   = (baud_q == CNT_LAST);
    // A push landing on the last stop-bit edge is taken so that back-to-back
    // frames run with no idle gap between stop bit and next start bit.
    assign uart_take = (state_q == S_IDLE) || ((state_q == S_STOP) && baud_tc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            baud_q  <= baud_nx;
            bit_q   <= bit_nx;
            shreg_q <= shreg_nx;
            tx_q    <= tx_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        baud_nx  = baud_q;
        bit_nx   = bit_q;
        shreg_nx = shreg_q;
        tx_nx    = tx_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (uart_push) begin
                    shreg_nx = iob.iob__mio_wdata[7:0];
                    tx_nx    = 1'b0;
                    baud_nx  = '0;
                    busy_nx  = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    baud_nx  = '0;
                    tx_nx    = shreg_q[0];
                    bit_nx   = '0;
                    state_nx = S_DATA;
                end else begin
                    baud_nx = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_nx = '0;
                    if (bit_q == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = S_STOP;
                    end else begin
                        shreg_nx = {1'b0, shreg_q[7:1]};
                        tx_nx    = shreg_q[1];
                        bit_nx   = bit_q + 3'd1;
                    end
                end else begin
                    baud_nx = baud_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_nx = '0;
                    done_nx = 1'b1;
                    if (uart_push) begin
                        shreg_nx = iob.iob__mio_wdata[7:0];
                        tx_nx    = 1'b0;
                        state_nx = S_START;
                    end else begin
                        busy_nx  = 1'b0;
                        state_nx = S_IDLE;
                    end
                end else begin
                    baud_nx = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= '0;
        end else if (gpio_push) begin
            gpio_q <= iob.iob__mio_wdata[GPIO_W-1:0];
        end
    end

    assign iob.mio__iob_done = done_q;
    assign mio__uart_tx      = tx_q;
    assign mio__uart_busy    = busy_q;
    assign mio__gpio_out     = gpio_q;

    // UART pushes while a frame is in flight are dropped; flag them in sim.
    ap_uart_push_when_busy: assert property (
        @(posedge clk) disable iff (rst) !(uart_push && !uart_take)
    ) else $warning("mio_ctrl: UART push dropped, transmitter busy");

endmodule
